// File: rtl/rcpu_pkg.sv
// Shared RCPU datapath constants and types used by the register file slice.
package rcpu_pkg;
  localparam int WORD_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int REG_COUNT  = 8;
  localparam int CNT_W      = 16;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]      cnt_t;
endpackage

// File: rtl/register_file_if.sv
// Bus between decode/writeback (master) and the register file (slave).
// Handshake: a read request is sampled on a rising edge; valid_x is high for
// exactly the cycle after each sampled request and out_x holds otherwise.
interface register_file_if;
  import rcpu_pkg::*;

  logic      en;
  reg_addr_t waddr;
  word_t     in;
  logic      rd_req_a;
  reg_addr_t raddr_a;
  word_t     out_a;
  logic      valid_a;
  logic      rd_req_b;
  reg_addr_t raddr_b;
  word_t     out_b;
  logic      valid_b;
  cnt_t      wr_count;

  modport master (
    output en, waddr, in, rd_req_a, raddr_a, rd_req_b, raddr_b,
    input  out_a, valid_a, out_b, valid_b, wr_count
  );

  modport slave (
    input  en, waddr, in, rd_req_a, raddr_a, rd_req_b, raddr_b,
    output out_a, valid_a, out_b, valid_b, wr_count
  );
endinterface

// File: rtl/register_file_read_port.sv
// One registered read port: same-edge write bypass, output hold, one-cycle valid.
module read_port
  import rcpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_req,
  input  reg_addr_t        raddr,
  input  logic             en,
  input  reg_addr_t        waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] out,
  output logic             valid
);
  logic             hit;
  logic [WIDTH-1:0] sel_data;

  always_comb begin
    hit      = en && (waddr == raddr);
    sel_data = hit ? wdata : rdata;
  end

  // out only moves on a request, so it holds the last read between requests
  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= rd_req;
      if (rd_req) out <= sel_data;
    end
  end
endmodule

// File: rtl/register_file.sv
// Eight-entry register file: one write port, two independent registered read ports.
module register_file
  import rcpu_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = REG_COUNT
) (
  input logic             clk,
  input logic             rst,
  register_file_if.slave  bus
);
  logic [WIDTH-1:0] mem [DEPTH];
  cnt_t             cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      cnt <= '0;
    end else if (bus.en) begin
      mem[bus.waddr] <= bus.in;
      cnt            <= cnt + cnt_t'(1);
    end
  end

  assign bus.wr_count = cnt;

  read_port #(.WIDTH(WIDTH)) u_port_a (
    .clk    (clk),
    .rst    (rst),
    .rd_req (bus.rd_req_a),
    .raddr  (bus.raddr_a),
    .en     (bus.en),
    .waddr  (bus.waddr),
    .wdata  (bus.in),
    .rdata  (mem[bus.raddr_a]),
    .out    (bus.out_a),
    .valid  (bus.valid_a)
  );

  read_port #(.WIDTH(WIDTH)) u_port_b (
    .clk    (clk),
    .rst    (rst),
    .rd_req (bus.rd_req_b),
    .raddr  (bus.raddr_b),
    .en     (bus.en),
    .waddr  (bus.waddr),
    .wdata  (bus.in),
    .rdata  (mem[bus.raddr_b]),
    .out    (bus.out_b),
    .valid  (bus.valid_b)
  );
endmodule
